// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
// The package also holds the forwarding-select helper used for both E-stage operands.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } mem_state_e;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M beats W because it holds the younger result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(input logic       reg_write_m,
                                         input logic [4:0] rd_m,
                                         input logic       reg_write_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of register indices/control bits from the datapath and the
// stall/flush/forward controls returned to it.
interface hazard_stall_controller_if #(parameter int CNT_W = 16);

  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemErr, StallCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, MemErr, StallCount
  );

endinterface

// File: rtl/hazard_stall_controller_mem_wait.sv
// Data-memory wait tracker: counts consecutive not-ready cycles and locks
// into ERROR once the wait exceeds MEM_TIMEOUT.
module hazard_stall_controller_mem_wait
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic mem_stall_o,
  output logic mem_err_o
);

  localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  mem_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next state, wait count and stall request
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_stall_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d     = ST_MEM_WAIT;
          wcnt_d      = WCNT_W'(1);
          mem_stall_o = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_MAX) begin
          state_d     = ST_ERROR;
          mem_stall_o = 1'b1;
        end else begin
          wcnt_d      = wcnt_q + WCNT_W'(1);
          mem_stall_o = 1'b1;
        end
      end
      ST_ERROR: begin
        state_d     = ST_ERROR;
        mem_stall_o = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
    mem_err_d = (state_d == ST_ERROR);
  end

  assign mem_err_o = mem_err_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: memory-wait stalls, branch flush, load-use
// interlock, operand forwarding and a saturating stalled-cycle counter.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);

  logic             mem_stall_s, mem_err_s, load_use_s;
  logic             stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic             flush_d_s, flush_e_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_stall_controller_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .mem_req_i   (bus.MemReqM),
    .mem_ready_i (bus.MemReadyM),
    .mem_stall_o (mem_stall_s),
    .mem_err_o   (mem_err_s)
  );

  assign load_use_s = (bus.ResultSrcE == RES_LOAD) && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // A memory stall freezes everything and defers the branch until release
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    if (mem_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (load_use_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      flush_e_s = 1'b0;
    end
  end

  // Saturating increment of the stalled-cycle count
  always_comb begin
    if (stall_f_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stalled-cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.StallF     = stall_f_s;
  assign bus.StallD     = stall_d_s;
  assign bus.StallE     = stall_e_s;
  assign bus.StallM     = stall_m_s;
  assign bus.FlushD     = flush_d_s;
  assign bus.FlushE     = flush_e_s;
  assign bus.ForwardAE  = fwd_sel(bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW, bus.Rs1E);
  assign bus.ForwardBE  = fwd_sel(bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW, bus.Rs2E);
  assign bus.MemErr     = mem_err_s;
  assign bus.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MEM_TIMEOUT = 4) with
// hand-computed expectations checked by immediate assertions.
module tb_hazard_stall_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hazard_stall_controller_if #(.CNT_W(16)) bus ();

  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE = 5'd0; bus.RdM = 5'd0; bus.RdW = 5'd0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.ResultSrcE = 2'b00;
    bus.PCSrcE = 1'b0; bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    clr_inputs();
    #12 rst = 1'b0;
    #1;

    // reset state
    check("rst_stallcount", 32'(bus.StallCount), 32'd0);
    check("rst_memerr", 32'(bus.MemErr), 32'd0);
    check("rst_stallf", 32'(bus.StallF), 32'd0);
    check("rst_fwda", 32'(bus.ForwardAE), 32'd0);

    // forwarding
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
    bus.Rs1E = 5'd5; bus.Rs2E = 5'd5;
    #1;
    check("fwd_a_m", 32'(bus.ForwardAE), 32'd2);
    check("fwd_b_m", 32'(bus.ForwardBE), 32'd2);
    bus.RdM = 5'd0;
    #1;
    check("fwd_a_w", 32'(bus.ForwardAE), 32'd1);
    bus.RegWriteW = 1'b0;
    #1;
    check("fwd_a_rf", 32'(bus.ForwardAE), 32'd0);
    bus.RdW = 5'd0; bus.RegWriteW = 1'b1; bus.RegWriteM = 1'b1; bus.Rs1E = 5'd0;
    #1;
    check("fwd_x0", 32'(bus.ForwardAE), 32'd0);
    bus.RdW = 5'd9; bus.Rs2E = 5'd9;
    #1;
    check("fwd_b_w", 32'(bus.ForwardBE), 32'd1);
    clr_inputs();

    // load-use on Rs2D
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1;
    check("lu_stallf", 32'(bus.StallF), 32'd1);
    check("lu_stalld", 32'(bus.StallD), 32'd1);
    check("lu_flushe", 32'(bus.FlushE), 32'd1);
    check("lu_flushd", 32'(bus.FlushD), 32'd0);
    check("lu_stalle", 32'(bus.StallE), 32'd0);
    tick();
    bus.ResultSrcE = 2'b00;
    #1;
    check("lu_cnt1", 32'(bus.StallCount), 32'd1);
    check("lu_released", 32'(bus.StallF), 32'd0);
    tick();
    check("lu_cnt_hold", 32'(bus.StallCount), 32'd1);
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd0; bus.Rs2D = 5'd0;
    #1;
    check("lu_x0", 32'(bus.StallF), 32'd0);
    bus.ResultSrcE = 2'b10; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1;
    check("lu_pc4", 32'(bus.StallF), 32'd0);
    clr_inputs();

    // branch beats load-use
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd3; bus.Rs1D = 5'd3; bus.PCSrcE = 1'b1;
    #1;
    check("br_flushd", 32'(bus.FlushD), 32'd1);
    check("br_flushe", 32'(bus.FlushE), 32'd1);
    check("br_stallf", 32'(bus.StallF), 32'd0);
    check("br_stalld", 32'(bus.StallD), 32'd0);
    tick();
    check("br_cnt", 32'(bus.StallCount), 32'd1);
    clr_inputs();

    // three-cycle memory wait
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd4; bus.Rs1D = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_stallf", 32'(bus.StallF), 32'd1);
      check("mw_stallm", 32'(bus.StallM), 32'd1);
      check("mw_flushe", 32'(bus.FlushE), 32'd0);
      tick();
    end
    bus.ResultSrcE = 2'b00;
    bus.MemReadyM = 1'b1;
    #1;
    check("mw_release", 32'(bus.StallE), 32'd0);
    tick();
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
    #1;
    check("mw_cnt", 32'(bus.StallCount), 32'd4);
    check("mw_memerr", 32'(bus.MemErr), 32'd0);
    check("mw_run", 32'(bus.StallF), 32'd0);
    clr_inputs();

    // branch held across a memory wait
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    #1;
    check("bw_noflush0", 32'(bus.FlushD), 32'd0);
    check("bw_stall0", 32'(bus.StallF), 32'd1);
    tick();
    check("bw_noflush1", 32'(bus.FlushE), 32'd0);
    tick();
    bus.MemReadyM = 1'b1;
    #1;
    check("bw_flushd", 32'(bus.FlushD), 32'd1);
    check("bw_flushe", 32'(bus.FlushE), 32'd1);
    check("bw_stallf", 32'(bus.StallF), 32'd0);
    tick();
    check("bw_cnt", 32'(bus.StallCount), 32'd6);
    clr_inputs();

    // timeout into ERROR
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_stall", 32'(bus.StallF), 32'd1);
      check("to_noerr", 32'(bus.MemErr), 32'd0);
      tick();
    end
    check("to_memerr", 32'(bus.MemErr), 32'd1);
    check("to_stallm", 32'(bus.StallM), 32'd1);
    check("to_cnt", 32'(bus.StallCount), 32'd11);
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b1;
    #1;
    check("err_absorb", 32'(bus.StallD), 32'd1);
    tick();
    check("err_sticky", 32'(bus.MemErr), 32'd1);
    check("err_cnt", 32'(bus.StallCount), 32'd12);

    // asynchronous reset mid-ERROR
    #2 rst = 1'b1;
    #1;
    check("arst_memerr", 32'(bus.MemErr), 32'd0);
    check("arst_cnt", 32'(bus.StallCount), 32'd0);
    check("arst_stallf", 32'(bus.StallF), 32'd0);
    rst = 1'b0;
    tick();
    check("arst_run", 32'(bus.StallE), 32'd0);
    check("arst_cnt_hold", 32'(bus.StallCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central hazard/sequencing controller for the 5-stage RISC-V pipeline. It drives stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers.
- Adds a multi-cycle data-memory wait FSM with timeout detection, and a saturating stall-cycle performance counter.
- Sits beside the datapath. Takes register indices and control bits from D/E/M/W; outputs go straight to the pipeline-register enables/clears and to the E-stage operand muxes.

Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles before the error state is entered (must be ≥1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  source registers of the instruction in D
- Rs1E, Rs2E  in  5  source registers of the instruction in E
- RdE, RdM, RdW  in  5  destination registers in E/M/W
- RegWriteM, RegWriteW  in  1  write-back enables in M/W
- ResultSrcE  in  2  2'b01 = load in E
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  data-memory access active in M
- MemReadyM  in  1  data memory completes this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE  out  1  clear the D or E pipeline register
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = ALUResultM, 01 = ResultW
- MemErr  out  1  sticky memory-timeout error
- StallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values: state = RUN, wait counter = 0, MemErr = 0, StallCount = 0. All combinational outputs then follow the rules below from RUN.
- FSM states: RUN, MEM_WAIT, ERROR (2-bit encoding).
- RUN → MEM_WAIT when MemReqM & ~MemReadyM; wait counter is loaded with 1.
- MEM_WAIT → RUN when MemReadyM.
  - If wait counter == MEM_TIMEOUT and ~MemReadyM → ERROR.
  - Otherwise the wait counter increments.
- ERROR: absorbing until reset; MemErr = 1.
- memStall (combinational) = (state == RUN & MemReqM & ~MemReadyM) | (state == MEM_WAIT & ~MemReadyM) | (state == ERROR).
- memStall asserted:
  - StallF = StallD = StallE = StallM = 1.
  - FlushD = FlushE = 0.
  - Load-use and branch handling are suppressed.
  - PCSrcE stays held in E, so the branch flush applies on the first cycle after release.
- memStall deasserted, priority order:
  1. Branch: PCSrcE → FlushD = FlushE = 1, StallF = StallD = 0. Branch beats load-use because the stalled D instruction is squashed.
  2. Load-use: ResultSrcE == 2'b01 & RdE != 0 & (RdE == Rs1D | RdE == Rs2D) → StallF = StallD = FlushE = 1.
  3. Otherwise all stall and flush outputs are 0.
- StallE and StallM are asserted only by memStall.
- Forwarding (combinational, independent of stalls):
  - ForwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rules with Rs2E.
  - M has priority over W.
- StallCount increments on each clock edge where StallF = 1 and saturates at all-ones.
- rst asserted mid-wait: immediate return to RUN; counters and MemErr clear asynchronously.
- x0 is never a hazard source or forwarding target.

Decomposition:
- Shared package constants:
  - FSM state encodings RUN/MEM_WAIT/ERROR.
  - ResultSrc encodings (ALU = 00, LOAD = 01, PC4 = 10).
  - Forward-select encodings FWD_RF = 00, FWD_W = 01, FWD_M = 10.
- One sub-module is natural: mem_wait_fsm, containing the state register, wait counter and MemErr. It outputs memStall.
- Forwarding and load-use/branch priority stay in the top level.

Test Plan:
- RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 → ForwardAE = 10. With RdM = 0 instead → ForwardAE = 01.
- ResultSrcE = 01, RdE = 7, Rs2D = 7 → StallF = StallD = FlushE = 1 for one cycle, StallCount 0→1. With RdE = 0 → no stall.
- Load-use (RdE = 3 = Rs1D) together with PCSrcE = 1 → FlushD = FlushE = 1, StallF = StallD = 0.
- MemReqM = 1, MemReadyM low for 3 cycles then high → StallF/D/E/M = 1 for 3 cycles, state returns to RUN, StallCount = 3, MemErr = 0.
- MEM_TIMEOUT = 4, MemReadyM never asserted → enters ERROR after the 5th stalled cycle. MemErr = 1 and stalls persist. rst pulse mid-ERROR → MemErr = 0, StallCount = 0, stalls released asynchronously.
- PCSrcE = 1 during MEM_WAIT → no flush while waiting; FlushD = FlushE = 1 on the first cycle after MemReadyM.
